lockin_bank: RTL

- Parametrised multi-channel lock-in demodulator; successor to the fixed two-lock-in X/Y channel processor.
- Multiplies one ADC stream by NCH sin/cos reference pairs, giving NCH X/Y pairs.
- Each product is boxcar-integrated over a programmable sample window, then dumped with a shift, saturation and a valid strobe.
- Sits between the ADC/NCO front end and the OPO lock PID loops.

---
 rtl/lockin_bank_if.sv | 30 +++
 rtl/lockin_bank.sv | 122 ++++++++++++
 2 files changed

// File: rtl/lockin_bank_if.sv
// Bus bundle for lockin_bank: ADC sample stream, NCO references, window control and X/Y results.
interface lockin_bank_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned IN_W  = 14,
    parameter int unsigned REF_W = 16,
    parameter int unsigned OUT_W = 24,
    parameter int unsigned WIN_W = 20
);
    logic signed [IN_W-1:0]      sig_in;
    logic                        sig_valid;
    logic        [NCH*REF_W-1:0] ref_sin;
    logic        [NCH*REF_W-1:0] ref_cos;
    logic        [WIN_W-1:0]     win_len;
    logic        [5:0]           out_shift;
    logic                        sync;
    logic        [NCH*OUT_W-1:0] x_out;
    logic        [NCH*OUT_W-1:0] y_out;
    logic                        out_valid;
    logic        [NCH-1:0]       sat_flag;

    modport master (
        output sig_in, sig_valid, ref_sin, ref_cos, win_len, out_shift, sync,
        input  x_out, y_out, out_valid, sat_flag
    );

    modport slave (
        input  sig_in, sig_valid, ref_sin, ref_cos, win_len, out_shift, sync,
        output x_out, y_out, out_valid, sat_flag
    );
endinterface

// File: rtl/lockin_bank.sv
// Multi-channel lock-in demodulator: per-channel sin/cos products, boxcar integration over a
// shared programmable window, then shifted and saturated X/Y dump with a one-cycle valid strobe.
module lockin_bank #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned IN_W  = 14,
    parameter int unsigned REF_W = 16,
    parameter int unsigned OUT_W = 24,
    parameter int unsigned ACC_W = 48,
    parameter int unsigned WIN_W = 20
) (
    input logic         clk,
    input logic         rst,
    lockin_bank_if.slave bus
);
    localparam int unsigned PROD_W = IN_W + REF_W;
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [PROD_W-1:0] px [NCH];
    logic signed [PROD_W-1:0] py [NCH];
    logic                     p_valid;
    logic signed [ACC_W-1:0]  acc_x [NCH];
    logic signed [ACC_W-1:0]  acc_y [NCH];
    logic        [WIN_W-1:0]  cnt;
    logic        [WIN_W-1:0]  len_lat;
    logic                     len_arm;

    logic        [WIN_W-1:0]  win_eff_c;
    logic                     dump_c;
    logic signed [PROD_W-1:0] prod_x_c [NCH];
    logic signed [PROD_W-1:0] prod_y_c [NCH];
    logic signed [ACC_W-1:0]  sum_x_c [NCH];
    logic signed [ACC_W-1:0]  sum_y_c [NCH];
    logic        [OUT_W:0]    clip_x_c [NCH];
    logic        [OUT_W:0]    clip_y_c [NCH];

    // Returns {clamped, value}: arithmetic shift then clamp to the signed OUT_W range.
    function automatic logic [OUT_W:0] clip(input logic signed [ACC_W-1:0] v,
                                            input logic        [5:0]       sh);
        logic signed [ACC_W-1:0] s;
        s = v >>> sh;
        if (s > OMAX)      clip = {1'b1, OMAX[OUT_W-1:0]};
        else if (s < OMIN) clip = {1'b1, OMIN[OUT_W-1:0]};
        else               clip = {1'b0, s[OUT_W-1:0]};
    endfunction

    always_comb begin
        win_eff_c = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
        dump_c    = p_valid && (cnt == len_lat - WIN_W'(1));
        for (int k = 0; k < NCH; k++) begin
            prod_x_c[k] = PROD_W'($signed(bus.sig_in))
                        * PROD_W'($signed(bus.ref_sin[k*REF_W +: REF_W]));
            prod_y_c[k] = PROD_W'($signed(bus.sig_in))
                        * PROD_W'($signed(bus.ref_cos[k*REF_W +: REF_W]));
            sum_x_c[k]  = acc_x[k] + ACC_W'(px[k]);
            sum_y_c[k]  = acc_y[k] + ACC_W'(py[k]);
            clip_x_c[k] = clip(sum_x_c[k], bus.out_shift);
            clip_y_c[k] = clip(sum_y_c[k], bus.out_shift);
        end
    end

    // Product stage, accumulate/dump stage and window bookkeeping; sync overrides a coincident dump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_valid       <= 1'b0;
            cnt           <= '0;
            len_lat       <= WIN_W'(1);
            len_arm       <= 1'b1;
            bus.x_out     <= '0;
            bus.y_out     <= '0;
            bus.sat_flag  <= '0;
            bus.out_valid <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                px[k]    <= '0;
                py[k]    <= '0;
                acc_x[k] <= '0;
                acc_y[k] <= '0;
            end
        end else begin
            len_arm       <= 1'b0;
            bus.out_valid <= 1'b0;
            if (len_arm) begin
                len_lat <= win_eff_c;
            end
            if (bus.sync) begin
                p_valid <= 1'b0;
                cnt     <= '0;
                len_lat <= win_eff_c;
                for (int k = 0; k < NCH; k++) begin
                    acc_x[k] <= '0;
                    acc_y[k] <= '0;
                end
            end else begin
                p_valid <= bus.sig_valid;
                if (bus.sig_valid) begin
                    for (int k = 0; k < NCH; k++) begin
                        px[k] <= prod_x_c[k];
                        py[k] <= prod_y_c[k];
                    end
                end
                if (dump_c) begin
                    cnt           <= '0;
                    len_lat       <= win_eff_c;
                    bus.out_valid <= 1'b1;
                    for (int k = 0; k < NCH; k++) begin
                        acc_x[k]                     <= '0;
                        acc_y[k]                     <= '0;
                        bus.x_out[k*OUT_W +: OUT_W]  <= clip_x_c[k][OUT_W-1:0];
                        bus.y_out[k*OUT_W +: OUT_W]  <= clip_y_c[k][OUT_W-1:0];
                        bus.sat_flag[k]              <= clip_x_c[k][OUT_W] | clip_y_c[k][OUT_W];
                    end
                end else if (p_valid) begin
                    cnt <= cnt + WIN_W'(1);
                    for (int k = 0; k < NCH; k++) begin
                        acc_x[k] <= sum_x_c[k];
                        acc_y[k] <= sum_y_c[k];
                    end
                end
            end
        end
    end
endmodule
